risc16_seq_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the RISC-16 core. Walks each instruction

---
 rtl/risc16_pkg.sv | 42 ++++
 rtl/risc16_wait_timer.sv | 30 +++
 rtl/risc16_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_risc16_seq_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared encodings for the RISC-16 multi-cycle control sequencer:
// opcodes, datapath select codes, ALU operations and FSM state encoding.
package risc16_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_NAND = 2'b01;
  localparam logic [1:0] ALU_OP_LUI  = 2'b10;
  localparam logic [1:0] ALU_OP_SUB  = 2'b11;

  // Ops that produce a register-file result (rA==0 is masked separately).
  function automatic logic op_writes_reg(input logic [2:0] op);
    return (op != OP_SW) && (op != OP_BEQ);
  endfunction

endpackage

// File: rtl/risc16_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access;
// flags the last cycle in which a memory ack may still be accepted.
module risc16_wait_timer
  import risc16_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count k-1 on the k-th waiting cycle: expire marks cycle TIMEOUT_CYC.
  assign o_expire = (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/risc16_seq_ctrl.sv
// Multi-cycle control sequencer for the RISC-16 core: FETCH/DECODE/EXEC/
// MEM/WB walk with PC, IR, register-file, ALU and memory handshake controls.
module risc16_seq_ctrl
  import risc16_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_load,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        bus_err
);

  state_t     r_state;
  logic       r_bus_err;
  logic [2:0] r_op;
  logic [2:0] r_ra;
  logic       r_imm_nz;

  logic w_in_wait;
  logic w_ack;
  logic w_expire;
  logic w_unused;

  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack     = ((r_state == S_FETCH) && imem_ack) ||
                     ((r_state == S_MEM)   && dmem_ack);
  assign w_unused  = ^instr[9:7];

  risc16_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_in_wait),
    .i_inc    (w_in_wait && !w_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_state <= S_DECODE;
          end else if (w_expire) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end
        end
        S_DECODE: r_state <= (r_op == OP_JALR && r_imm_nz) ? S_HALT : S_EXEC;
        S_EXEC:   r_state <= (r_op == OP_SW || r_op == OP_LW) ? S_MEM : S_WB;
        S_MEM: begin
          if (dmem_ack) begin
            r_state <= S_WB;
          end else if (w_expire) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end
        end
        S_WB:     r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Instruction fields captured alongside the datapath IR load.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && imem_ack) begin
      r_op     <= instr[15:13];
      r_ra     <= instr[12:10];
      r_imm_nz <= |instr[6:0];
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    alu_op      = ALU_OP_ADD;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_SEL_ALU;
    pc_en       = 1'b0;
    pc_sel      = PC_SEL_INC;
    halted      = 1'b0;
    bus_err     = 1'b0;

    // ALU controls appear in EXEC and stay stable through MEM and WB.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (r_op)
        OP_ADD:  alu_op = ALU_OP_ADD;
        OP_NAND: alu_op = ALU_OP_NAND;
        OP_LUI:  alu_op = ALU_OP_LUI;
        OP_BEQ:  alu_op = ALU_OP_SUB;
        default: alu_op = ALU_OP_ADD;
      endcase
      alu_src_imm = (r_op == OP_ADDI) || (r_op == OP_SW) ||
                    (r_op == OP_LW)   || (r_op == OP_JALR);
    end

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_op == OP_SW);
      end
      S_WB: begin
        pc_en  = 1'b1;
        reg_we = op_writes_reg(r_op) && (r_ra != 3'd0);
        if (r_op == OP_LW)        wb_sel = WB_SEL_MEM;
        else if (r_op == OP_JALR) wb_sel = WB_SEL_PC;
        if (r_op == OP_BEQ && alu_zero) pc_sel = PC_SEL_BR;
        else if (r_op == OP_JALR)       pc_sel = PC_SEL_ALU;
      end
      S_HALT: begin
        halted  = 1'b1;
        bus_err = r_bus_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc16_seq_ctrl.sv
// Directed bench for risc16_seq_ctrl: a table of single-instruction
// transactions plus hand-written halt, timeout and reset sequences.
module tb_risc16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, dmem_ack, alu_zero;
  logic [15:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_load, alu_src_imm;
  logic        reg_we, pc_en, halted, bus_err;
  logic [1:0]  alu_op, wb_sel, pc_sel;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  risc16_seq_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel),
    .halted(halted), .bus_err(bus_err)
  );

  typedef struct {
    string       name;
    logic [15:0] ins;
    int          idel;
    int          ddel;
    logic        zero;
    int          cycles;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_op;
    logic        alu_src;
    int          dreq;
    logic        dwe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    alu_zero = 1'b0; instr = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; returns after its WB cycle.
  task automatic run_vec(input vec_t v);
    int fcnt = 0, dcnt = 0, cyc = 0;
    logic dwe_seen = 1'b0, irl = 1'b0, done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk); #1;
      imem_ack = imem_req && (fcnt == v.idel);
      dmem_ack = dmem_req && (dcnt == v.ddel);
      instr    = v.ins;
      alu_zero = v.zero;
      if (imem_req) fcnt++;
      if (dmem_req) begin dcnt++; dwe_seen = dwe_seen | dmem_we; end
      #1;
      if (imem_ack) irl = ir_load;
      cyc++;
      if (pc_en) begin
        done = 1'b1;
        chk({v.name, " cycles"},  cyc, v.cycles);
        chk({v.name, " reg_we"},  int'(reg_we), int'(v.reg_we));
        chk({v.name, " wb_sel"},  int'(wb_sel), int'(v.wb_sel));
        chk({v.name, " pc_sel"},  int'(pc_sel), int'(v.pc_sel));
        chk({v.name, " alu_op"},  int'(alu_op), int'(v.alu_op));
        chk({v.name, " alu_src"}, int'(alu_src_imm), int'(v.alu_src));
        chk({v.name, " dmem_req_cycles"}, dcnt, v.dreq);
        chk({v.name, " dmem_we"}, int'(dwe_seen), int'(v.dwe));
        chk({v.name, " ir_load"}, int'(irl), 1);
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!done) chk({v.name, " reached_wb"}, 0, 1);
  endtask

  initial begin
    int cnt;
    //          name       instr    idl ddl z  cyc we wb     pc     alu    src dreq dwe
    vecs[0]  = '{"addi_r1",   16'h2481, 0, 0, 0, 4,  1, 2'b00, 2'b00, 2'b00, 1, 0, 0};
    vecs[1]  = '{"beq_taken", 16'hC07E, 0, 0, 1, 4,  0, 2'b00, 2'b01, 2'b11, 0, 0, 0};
    vecs[2]  = '{"beq_not",   16'hC07E, 0, 0, 0, 4,  0, 2'b00, 2'b00, 2'b11, 0, 0, 0};
    vecs[3]  = '{"lw_wait3",  16'hA482, 0, 3, 0, 8,  1, 2'b01, 2'b00, 2'b00, 1, 4, 0};
    vecs[4]  = '{"jalr_link", 16'hE500, 0, 0, 0, 4,  1, 2'b10, 2'b10, 2'b00, 1, 0, 0};
    vecs[5]  = '{"add_r0",    16'h0000, 0, 0, 0, 4,  0, 2'b00, 2'b00, 2'b00, 0, 0, 0};
    vecs[6]  = '{"sw",        16'h8482, 0, 0, 0, 5,  0, 2'b00, 2'b00, 2'b00, 1, 1, 1};
    vecs[7]  = '{"nand_r1",   16'h4403, 0, 0, 0, 4,  1, 2'b00, 2'b00, 2'b01, 0, 0, 0};
    vecs[8]  = '{"lui_r3",    16'h6C00, 0, 0, 0, 4,  1, 2'b00, 2'b00, 2'b10, 0, 0, 0};
    vecs[9]  = '{"addi_iw2",  16'h2481, 2, 0, 0, 6,  1, 2'b00, 2'b00, 2'b00, 1, 0, 0};
    vecs[10] = '{"addi_iw15", 16'h2481, 15, 0, 0, 19, 1, 2'b00, 2'b00, 2'b00, 1, 0, 0};

    // Reset state and IDLE without run.
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("idle_imem_req", int'(imem_req), 0);
    chk("idle_pc_en",    int'(pc_en), 0);
    chk("idle_halted",   int'(halted), 0);
    chk("idle_outputs",  int'({dmem_req, dmem_we, ir_load, alu_op, alu_src_imm,
                               reg_we, wb_sel, pc_sel, bus_err}), 0);

    run = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);

    // JALR with nonzero imm7 halts from DECODE without a PC update.
    cnt = 0;
    @(negedge clk); #1;
    instr = 16'hE001; imem_ack = imem_req;
    #1;
    chk("halt_fetch_ir_load", int'(ir_load), 1);
    while (!halted && cnt < 10) begin
      @(negedge clk); #1;
      imem_ack = 1'b0;
      if (pc_en) chk("halt_no_pc_en", int'(pc_en), 0);
      cnt++;
    end
    chk("halt_latency", cnt, 2);
    for (int k = 0; k < 5; k++) begin
      run = k[0];
      imem_ack = 1'b1;
      @(negedge clk); #1;
      chk("halt_halted", int'(halted), 1);
      chk("halt_no_req", int'(imem_req | pc_en | reg_we | dmem_req), 0);
    end
    chk("halt_bus_err", int'(bus_err), 0);

    // Fetch never acknowledged: 16 request cycles, then bus-error halt.
    do_reset();
    run = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40 && !halted; k++) begin
      @(negedge clk); #1;
      if (imem_req) cnt++;
    end
    chk("timeout_req_cycles", cnt, 16);
    chk("timeout_halted",     int'(halted), 1);
    chk("timeout_bus_err",    int'(bus_err), 1);
    chk("timeout_req_low",    int'(imem_req), 0);

    // Reset while a data access is outstanding.
    do_reset();
    run = 1'b1;
    @(negedge clk); #1;
    instr = 16'hA482; imem_ack = imem_req;
    cnt = 0;
    for (int k = 0; k < 10 && cnt < 2; k++) begin
      @(negedge clk); #1;
      imem_ack = 1'b0;
      if (dmem_req) cnt++;
    end
    chk("midmem_req_seen", cnt, 2);
    rst = 1'b1; run = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("midmem_outputs", int'({imem_req, dmem_req, dmem_we, ir_load, alu_op,
                                alu_src_imm, reg_we, wb_sel, pc_en, pc_sel,
                                halted, bus_err}), 0);
    @(negedge clk); #1;
    chk("midmem_stays_idle", int'(imem_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
